car_sensor_driver: RTL and testbench

Transmit side of the parking-lot two-sensor interface. On request, generates the outer/inner photo-sensor waveform a car makes when entering or exiting. Output shapes and timing match what carDetection consumes. Used as an on-board stimulus source in place of breadboard switches and as the loopback driver in carDetection/carCounter benches.

---
 rtl/car_sensor_pkg.sv | 50 +++++
 rtl/car_sensor_driver.sv | 124 ++++++++++++
 tb/tb_car_sensor_driver.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/car_sensor_pkg.sv
// car_sensor_pkg
// Shared types and constants for the two-sensor (outer/inner) car event driver.
//   state_t      : driver FSM states
//   DIR_*        : direction encoding (1 = enter, 0 = exit)
//   ENTER_/EXIT_ : {outer,inner} patterns for phases P1..P3, CLEAR for idle/gap
//   pattern()    : maps a state and direction to its {outer,inner} pattern
package car_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    P2,
    P3,
    GAP
  } state_t;

  localparam logic DIR_ENTER = 1'b1;
  localparam logic DIR_EXIT  = 1'b0;

  // {outer, inner}. Consecutive phases differ in exactly one bit.
  localparam logic [1:0] ENTER_P1 = 2'b10;
  localparam logic [1:0] ENTER_P2 = 2'b11;
  localparam logic [1:0] ENTER_P3 = 2'b01;
  localparam logic [1:0] EXIT_P1  = 2'b01;
  localparam logic [1:0] EXIT_P2  = 2'b11;
  localparam logic [1:0] EXIT_P3  = 2'b10;
  localparam logic [1:0] CLEAR    = 2'b00;

  function automatic logic [1:0] pattern(input state_t s, input logic d);
    logic [1:0] p;
    p = CLEAR;
    if (d == DIR_ENTER) begin
      case (s)
        P1:      p = ENTER_P1;
        P2:      p = ENTER_P2;
        P3:      p = ENTER_P3;
        default: p = CLEAR;
      endcase
    end else if (d == DIR_EXIT) begin
      case (s)
        P1:      p = EXIT_P1;
        P2:      p = EXIT_P2;
        P3:      p = EXIT_P3;
        default: p = CLEAR;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/car_sensor_driver.sv
// car_sensor_driver
// Generates the outer/inner photo-sensor waveform of one car entering or
// exiting. Each of P1, P2, P3 and the trailing GAP is held for DWELL cycles.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low
//   start   : request one car event (accepted only while ready)
//   dir     : 1 = enter, 0 = exit, sampled on the accept edge
//   abort   : cancel an in-flight event (honoured in P1..P3 only)
//   ready   : high in IDLE
//   busy    : high outside IDLE (~ready)
//   outer   : outer sensor, 1 = blocked (registered)
//   inner   : inner sensor, 1 = blocked (registered)
//   done    : one-cycle pulse on the last GAP cycle of a completed event
//   aborted : one-cycle pulse on the last GAP cycle of a cancelled event
module car_sensor_driver
  import car_sensor_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic dir,
  input  logic abort,
  output logic ready,
  output logic busy,
  output logic outer,
  output logic inner,
  output logic done,
  output logic aborted
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("car_sensor_driver: DWELL must be in 1..65535");
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dir_q, dir_n;
  logic          abort_flag, abort_flag_n;
  logic [1:0]    oi_n;
  logic          last;

  assign last = (cnt == LAST);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt + 1'b1;
    dir_n        = dir_q;
    abort_flag_n = abort_flag;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // start has priority over abort here; abort is simply not looked at.
        if (start) begin
          state_n = P1;
          dir_n   = dir;
        end
      end
      P1, P2, P3: begin
        if (abort) begin
          state_n      = GAP;
          cnt_n        = '0;
          abort_flag_n = 1'b1;
        end else if (last) begin
          state_n = (state == P1) ? P2 : (state == P2) ? P3 : GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (last) begin
          state_n      = IDLE;
          cnt_n        = '0;
          abort_flag_n = 1'b0;
        end
      end
      default: begin
        state_n      = IDLE;
        cnt_n        = '0;
        abort_flag_n = 1'b0;
      end
    endcase

    oi_n = pattern(state_n, dir_n);
  end

  // Outputs are computed from the next state so that, once registered, they
  // line up with the state they describe (e.g. done lands on the last GAP
  // cycle, including DWELL=1 where GAP is a single cycle).
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      dir_q      <= 1'b0;
      abort_flag <= 1'b0;
      ready      <= 1'b1;
      outer      <= 1'b0;
      inner      <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dir_q      <= dir_n;
      abort_flag <= abort_flag_n;
      ready      <= (state_n == IDLE);
      outer      <= oi_n[1];
      inner      <= oi_n[0];
      done       <= (state_n == GAP) && (cnt_n == LAST) && !abort_flag_n;
      aborted    <= (state_n == GAP) && (cnt_n == LAST) &&  abort_flag_n;
    end
  end

  assign busy = ~ready;

endmodule

// File: tb/tb_car_sensor_driver.sv
// tb_car_sensor_driver
// Directed bench for car_sensor_driver. dut4 (DWELL=4) covers enter/exit,
// ignored start/abort, abort in P2, start-vs-abort priority and reset
// mid-event; dut1 (DWELL=1) covers back-to-back events with start held high.
module tb_car_sensor_driver;
  import car_sensor_pkg::*;

  localparam int D = 4;

  logic clk;
  logic reset;
  logic start, dir, abort;
  logic ready, busy, outer, inner, done, aborted;
  logic start1, dir1, abort1;
  logic ready1, busy1, outer1, inner1, done1, aborted1;

  int checks = 0;
  int errors = 0;

  car_sensor_driver #(.DWELL(D)) dut4 (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
    .ready(ready), .busy(busy), .outer(outer), .inner(inner),
    .done(done), .aborted(aborted)
  );

  car_sensor_driver #(.DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .dir(dir1), .abort(abort1),
    .ready(ready1), .busy(busy1), .outer(outer1), .inner(inner1),
    .done(done1), .aborted(aborted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int idx,
                       input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks n cycles of one phase on dut4. The last cycle's done/aborted are
  // the expected pulse values. pulse_kind 1 raises start, 2 raises abort for
  // the single cycle pulse_at (its effect is on the following edge).
  task automatic phase(input string tag, input logic [1:0] exp_oi, input int n,
                       input logic exp_done, input logic exp_ab,
                       input int pulse_at, input int pulse_kind);
    for (int i = 0; i < n; i++) begin
      check({tag, ".oi"}, i, {outer, inner}, exp_oi);
      check({tag, ".done"}, i, {1'b0, done}, {1'b0, (i == n - 1) && exp_done});
      check({tag, ".aborted"}, i, {1'b0, aborted}, {1'b0, (i == n - 1) && exp_ab});
      check({tag, ".rdy_bsy"}, i, {ready, busy}, 2'b01);
      if (i == pulse_at && pulse_kind == 1) start = 1'b1;
      if (i == pulse_at && pulse_kind == 2) abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, ".oi"}, 0, {outer, inner}, 2'b00);
    check({tag, ".rdy_bsy"}, 0, {ready, busy}, 2'b10);
    check({tag, ".pulses"}, 0, {done, aborted}, 2'b00);
  endtask

  initial begin
    logic [1:0] exp_seq [10];
    reset = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0;
    start1 = 1'b0; dir1 = 1'b0; abort1 = 1'b0;
    #12;
    idle_check("reset");
    check("reset1", 0, {ready1, busy1}, 2'b10);
    reset = 1'b1;
    tick();
    idle_check("idle");

    // Enter; dir flipped right after accept must not matter.
    start = 1'b1; dir = DIR_ENTER;
    tick();
    start = 1'b0; dir = DIR_EXIT;
    phase("en.p1", 2'b10, D, 1'b0, 1'b0, -1, 0);
    phase("en.p2", 2'b11, D, 1'b0, 1'b0, -1, 0);
    phase("en.p3", 2'b01, D, 1'b0, 1'b0, -1, 0);
    phase("en.gap", 2'b00, D, 1'b1, 1'b0, -1, 0);
    idle_check("en.end");
    tick();

    // Exit; abort in GAP is ignored.
    start = 1'b1; dir = DIR_EXIT;
    tick();
    start = 1'b0;
    phase("ex.p1", 2'b01, D, 1'b0, 1'b0, -1, 0);
    phase("ex.p2", 2'b11, D, 1'b0, 1'b0, -1, 0);
    phase("ex.p3", 2'b10, D, 1'b0, 1'b0, -1, 0);
    phase("ex.gap", 2'b00, D, 1'b1, 1'b0, 1, 2);
    idle_check("ex.end");

    // start pulsed at t+6 while busy: ignored, single done.
    start = 1'b1; dir = DIR_ENTER;
    tick();
    start = 1'b0;
    phase("bs.p1", 2'b10, D, 1'b0, 1'b0, -1, 0);
    phase("bs.p2", 2'b11, D, 1'b0, 1'b0, 1, 1);
    phase("bs.p3", 2'b01, D, 1'b0, 1'b0, -1, 0);
    phase("bs.gap", 2'b00, D, 1'b1, 1'b0, -1, 0);
    idle_check("bs.end");
    tick();
    idle_check("bs.end2");

    // start and abort together in IDLE: start wins; abort at t+6 in P2.
    start = 1'b1; abort = 1'b1; dir = DIR_ENTER;
    tick();
    start = 1'b0; abort = 1'b0;
    phase("ab.p1", 2'b10, D, 1'b0, 1'b0, -1, 0);
    phase("ab.p2", 2'b11, 2, 1'b0, 1'b0, 1, 2);
    phase("ab.gap", 2'b00, D, 1'b0, 1'b1, -1, 0);
    idle_check("ab.end");

    // Reset asserted mid-P3: immediate clear, no pulses.
    start = 1'b1; dir = DIR_ENTER;
    tick();
    start = 1'b0;
    phase("rs.p1", 2'b10, D, 1'b0, 1'b0, -1, 0);
    phase("rs.p2", 2'b11, D, 1'b0, 1'b0, -1, 0);
    phase("rs.p3", 2'b01, 2, 1'b0, 1'b0, -1, 0);
    #2 reset = 1'b0;
    #1;
    idle_check("rs.async");
    tick();
    idle_check("rs.held");
    reset = 1'b1;
    tick();
    idle_check("rs.rel");
    start = 1'b1; dir = DIR_EXIT;
    tick();
    start = 1'b0;
    phase("rx.p1", 2'b01, D, 1'b0, 1'b0, -1, 0);
    phase("rx.p2", 2'b11, D, 1'b0, 1'b0, -1, 0);
    phase("rx.p3", 2'b10, D, 1'b0, 1'b0, -1, 0);
    phase("rx.gap", 2'b00, D, 1'b1, 1'b0, -1, 0);
    idle_check("rx.end");

    // DWELL=1, start held high, alternating dir: period of 5 cycles.
    exp_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00,
                2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    start1 = 1'b1; dir1 = DIR_ENTER;
    tick();
    for (int k = 0; k < 20; k++) begin
      check("b2b.oi", k, {outer1, inner1}, exp_seq[k % 10]);
      check("b2b.pulses", k, {done1, aborted1}, {(k % 5) == 3, 1'b0});
      check("b2b.ready", k, {ready1, busy1}, ((k % 5) == 4) ? 2'b10 : 2'b01);
      if ((k % 5) == 4) dir1 = ~dir1;
      tick();
    end
    start1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
